neuron_loader: RTL and testbench
================================

# neuron_loader

Input-side writer for the MLP datapath. Accepts a stream of signed 16-bit input activations over a valid/ready handshake, writes them sequentially into neuron memory, then pulses a start to the control unit. Once the pipeline reports completion, it re-arms for the next sample. It owns the neuron-memory write port only while the pipeline is idle.

## Interface
- `NUM_INPUTS`, 784: number of input activations per sample (1..2^ADDR_W).
- `BASE_ADDR`, 0: neuron-memory address of the first input activation.
- `ADDR_W`, 12: neuron-memory address width.
- `DATA_W`, 16: activation width, signed two's complement.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_en` in 1: request to load one sample; sampled only in IDLE.
- `in_valid` in 1: upstream data valid.
- `in_data` in DATA_W: signed activation.
- `in_ready` out 1: loader can accept `in_data` this cycle.
- `write_enable` out 1: neuron-memory write strobe.
- `write_addr` out ADDR_W: neuron-memory write address.
- `write_data` out DATA_W: neuron-memory write data.
- `start` out 1: one-cycle pulse that launches the control unit.
- `finished` in 1: completion from the softmax stage; level or pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT_DONE.
- IDLE:
  - `in_ready`=0.
  - `load_en`=1 moves to LOAD and clears the count to 0.
- LOAD:
  - `in_ready`=1.
  - Each cycle with `in_valid && in_ready` is a transfer.
  - A transfer registers `write_enable`=1, `write_addr`=BASE_ADDR+count and `write_data`=in_data, then increments count.
  - On the transfer with count==NUM_INPUTS-1, the FSM moves to START and `in_ready` drops the next cycle.
  - `in_valid`=0 stalls the load with no write and no count change.
- START: `start`=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE:
  - `in_ready`=0.
  - `finished`=1 returns the FSM to IDLE.
  - `finished` seen in any other state is ignored.
- Address arithmetic is ADDR_W-bit unsigned and wraps modulo 2^ADDR_W. Wrap is legal but not checked.
- Data passes through unmodified, with no sign change or saturation.
- `load_en` held high across IDLE re-entry starts a new load immediately.
- Reset in any state:
  - Returns to IDLE and clears count.
  - Any write registered that cycle is dropped.

## Timing
- Reset values: `in_ready`=0, `write_enable`=0, `write_addr`=0, `write_data`=0, `start`=0, `busy`=0.
- Write latency: a transfer at cycle N drives `write_enable` and its address/data at cycle N+1, for one cycle.
- Throughput: one activation per cycle while `in_valid` stays high.
- `start` asserts the cycle after the final write strobe, so the last write is in memory before the control unit's first read.
- `in_ready` is a registered function of state. It is never combinationally dependent on `in_valid`.
- `busy` rises the cycle after `load_en` is accepted and falls the cycle after `finished` is seen in WAIT_DONE.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [DATA_W-1:0], the modulo-2^DATA_W sum of all accepted `in_data` for the current sample.
  - Cleared on entry to LOAD and on reset.
  - Updated one cycle after each transfer.
  - Stable from START until the next load.
- `LOADER_CHECKSUM_EN` undefined: no `checksum` port and no adder. All other behaviour is identical.

## Structure
- Shared package `mlp_pkg` holds:
  - Constants `ADDR_W`, `DATA_W`, `NUM_INPUTS`.
  - The loader state enum (IDLE/LOAD/START/WAIT_DONE), so the control unit and benches decode `busy`/state consistently.
- One natural sub-module, `load_addr_counter`:
  - Count register with clear, enable and a terminal-count flag at NUM_INPUTS-1.
  - Adds BASE_ADDR to produce `write_addr`.

## Test plan
- Bench uses NUM_INPUTS=4, BASE_ADDR=0x010.
- Basic load:
  - Stimulus: `load_en` pulse, then `in_data`=0x0001, 0xFFFF, 0x7FFF, 0x8000 on consecutive valid cycles.
  - Required: writes to 0x010..0x013 with those values, then `start` high exactly one cycle after the 0x013 write.
- Stall:
  - Stimulus: `in_valid` deasserted for 3 cycles between the 2nd and 3rd words.
  - Required: no `write_enable` during the gap, addresses stay contiguous, and 4 writes total.
- Re-arm:
  - Stimulus: `finished`=1 in WAIT_DONE, then a second load.
  - Required: `busy` falls, then the second load again writes from 0x010.
  - Required: `finished` pulsed during LOAD has no effect.
- Reset mid-load:
  - Stimulus: `reset` after 2 transfers.
  - Required: all outputs return to reset values the next cycle, and the next load starts at 0x010.
- Checksum, with `LOADER_CHECKSUM_EN`:
  - Stimulus: the basic-load data.
  - Required: `checksum`=0x0001+0xFFFF+0x7FFF+0x8000 mod 2^16 = 0xFFFF at START.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared MLP constants and the loader state encoding, so the control unit
// and benches decode loader state the same way.
package mlp_pkg;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int NUM_INPUTS = 784;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;
endpackage

// File: rtl/load_addr_counter.sv
// Activation counter for the loader: clear/enable count, terminal flag at
// NUM_INPUTS-1, and the base-offset neuron-memory address.
module load_addr_counter #(
  parameter int                NUM_INPUTS = 784,
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_INPUTS - 1);

  logic [ADDR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en)      count <= count + 1'b1;
  end

  // Modulo-2^ADDR_W; wrap past the top of memory is allowed.
  assign addr = count + BASE_ADDR;
  assign last = (count == LAST_CNT);
endmodule

// File: rtl/neuron_loader.sv
// Streams one sample of activations into neuron memory, then pulses start.
// Optional LOADER_CHECKSUM_EN adds a running modulo-2^DATA_W input sum.
module neuron_loader #(
  parameter int                NUM_INPUTS = mlp_pkg::NUM_INPUTS,
  parameter int                ADDR_W     = mlp_pkg::ADDR_W,
  parameter int                DATA_W     = mlp_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              start,
  input  logic              finished,
  output logic              busy
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  import mlp_pkg::*;

  loader_state_t     state, state_next;
  logic              clr, xfer, last;
  logic [ADDR_W-1:0] cnt_addr;

  assign xfer = in_valid && in_ready;

  load_addr_counter #(
    .NUM_INPUTS (NUM_INPUTS),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (xfer),
    .addr  (cnt_addr),
    .last  (last)
  );

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    unique case (state)
      IDLE: if (load_en) begin
        state_next = LOAD;
        clr        = 1'b1;
      end
      LOAD:      if (xfer && last) state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (finished) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs registered from next state so in_ready never depends on in_valid;
  // start lags START by one cycle so it follows the final write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      start        <= 1'b0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      state        <= state_next;
      in_ready     <= (state_next == LOAD);
      busy         <= (state_next != IDLE);
      start        <= (state == START);
      write_enable <= xfer;
      if (xfer) begin
        write_addr <= cnt_addr;
        write_data <= in_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || clr) checksum <= '0;
    else if (xfer)    checksum <= checksum + in_data;
  end
`endif
endmodule

// File: tb/tb_neuron_loader.sv
// Directed bench for neuron_loader: basic load, stall, re-arm, reset mid-load
// and, with LOADER_CHECKSUM_EN, the checksum value at start.
module tb_neuron_loader;
  localparam int             NI = 4;
  localparam int             AW = 12;
  localparam int             DW = 16;
  localparam logic [AW-1:0]  BA = 12'h010;

  logic          clk = 1'b0;
  logic          reset, load_en, in_valid, finished;
  logic [DW-1:0] in_data;
  logic          in_ready, write_enable, start, busy;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  neuron_loader #(
    .NUM_INPUTS (NI),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .BASE_ADDR  (BA)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .start        (start),
    .finished     (finished),
    .busy         (busy)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/start log sampled on the falling edge.
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wc[$];
  int            sc[$];
  always @(negedge clk) begin
    if (write_enable) begin
      wa.push_back(write_addr);
      wd.push_back(write_data);
      wc.push_back(cyc);
    end
    if (start) sc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] vec [NI] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".we"},       32'(write_enable), 0);
    chk({tag, ".addr"},     32'(write_addr), 0);
    chk({tag, ".data"},     32'(write_data), 0);
    chk({tag, ".start"},    32'(start), 0);
    chk({tag, ".busy"},     32'(busy), 0);
  endtask

  // Full load of vec[]; optional 3-cycle stall before word 2 and a
  // finished pulse during LOAD that must be ignored.
  task automatic run_load(input string tag, input bit stall, input bit fin_mid);
    int  w0, s0, n;
    bit  seen;
    w0 = wa.size();
    s0 = sc.size();
    @(negedge clk) load_en = 1'b1;
    @(negedge clk) load_en = 1'b0;
    chk({tag, ".busy_rise"}, 32'(busy), 1);
    chk({tag, ".ready"},     32'(in_ready), 1);
    for (int i = 0; i < NI; i++) begin
      if (i == 2 && stall) begin
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, ".ready_stall"}, 32'(in_ready), 1);
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      finished = fin_mid && (i == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    finished = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (sc.size() > s0) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, ".start_seen"}, 32'(seen), 1);
`ifdef LOADER_CHECKSUM_EN
    chk({tag, ".checksum"}, 32'(checksum), 32'h0000FFFF);
`endif
    n = wa.size() - w0;
    chk({tag, ".nwrites"}, 32'(n), NI);
    if (n >= NI) begin
      for (int i = 0; i < NI; i++) begin
        chk({tag, $sformatf(".addr%0d", i)}, 32'(wa[w0+i]), 32'(BA) + 32'(i));
        chk({tag, $sformatf(".data%0d", i)}, 32'(wd[w0+i]), 32'(vec[i]));
      end
      chk({tag, ".span"}, 32'(wc[w0+NI-1] - wc[w0]), stall ? 6 : 3);
      if (seen) chk({tag, ".start_lat"}, 32'(sc[s0] - wc[w0+NI-1]), 1);
    end
    @(negedge clk);
    chk({tag, ".start_pulse"}, 32'(start), 0);
    chk({tag, ".ready_wait"},  32'(in_ready), 0);
    chk({tag, ".busy_wait"},   32'(busy), 1);
  endtask

  task automatic rearm(input string tag);
    finished = 1'b1;
    @(negedge clk) finished = 1'b0;
    chk({tag, ".busy_fall"}, 32'(busy), 0);
    chk({tag, ".ready_idle"}, 32'(in_ready), 0);
  endtask

  initial begin
    reset    = 1'b1;
    load_en  = 1'b0;
    in_valid = 1'b0;
    finished = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    run_load("basic", 1'b0, 1'b0);
    rearm("basic");

    run_load("stall", 1'b1, 1'b1);
    rearm("stall");

    // Reset lands on the cycle a third word would transfer.
    @(negedge clk) load_en = 1'b1;
    @(negedge clk) load_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      @(negedge clk);
    end
    reset    = 1'b1;
    in_data  = 16'h1234;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk("midrst.we_after", 32'(write_enable), 0);

    run_load("post_rst", 1'b0, 1'b0);
    rearm("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
